// File: rtl/usb3_rx_skp_descramble_p.sv
// USB 3.0 RX front end: strips SKP symbols, repacks survivors into dense NSYM-symbol words, descrambles data symbols.
// Optional saturating SKP/COM totals are enabled with the USB3_RX_DESCR_STATS_EN macro.
module usb3_rx_skp_descramble_p #(
    parameter int          NSYM      = 4,
    parameter int          ACC_SYMS  = 2*NSYM,
    parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
    input  logic              local_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [8*NSYM-1:0] in_data,
    input  logic [NSYM-1:0]   in_datak,
    output logic              out_valid,
    output logic [8*NSYM-1:0] out_data,
    output logic [NSYM-1:0]   out_datak,
    output logic              lfsr_locked,
    output logic [3:0]        skp_strip_cnt
`ifdef USB3_RX_DESCR_STATS_EN
    ,
    output logic [15:0]       skp_total,
    output logic [15:0]       com_total
`endif
);

    localparam int         CW      = $clog2(NSYM + 1);
    localparam int         DW      = $clog2(ACC_SYMS + 1);
    localparam logic [7:0] SKP_SYM = 8'h3C;
    localparam logic [7:0] COM_SYM = 8'hBC;

    typedef logic [NSYM-1:0][7:0]     word_t;
    typedef logic [ACC_SYMS-1:0][7:0] acc_t;

    // Eight shifts of the x^16+x^5+x^4+x^3+1 Galois LFSR; returns {next_state, keystream_byte}.
    function automatic logic [23:0] lfsr_byte(input logic [15:0] seed);
        logic [15:0] s;
        logic [7:0]  key;
        logic        fb;
        s   = seed;
        key = '0;
        for (int b = 0; b < 8; b++) begin
            fb     = s[15];
            key[b] = fb;
            s      = {s[14:5], s[4] ^ fb, s[3] ^ fb, s[2] ^ fb, s[1], s[0], fb};
        end
        return {s, key};
    endfunction

    word_t             s1_data_q, s1_data_d;
    logic [NSYM-1:0]   s1_datak_q, s1_datak_d;
    logic [CW-1:0]     s1_cnt_q, s1_cnt_d;
    logic [CW-1:0]     s1_skp_q, s1_skp_d;

    acc_t              acc_data_q, acc_data_d;
    logic [ACC_SYMS-1:0] acc_datak_q, acc_datak_d;
    logic [DW-1:0]     depth_q, depth_d;

    logic              s2_valid_q, s2_valid_d;
    word_t             s2_data_q, s2_data_d;
    logic [NSYM-1:0]   s2_datak_q, s2_datak_d;
    logic [CW-1:0]     s2_skp_q, s2_skp_d;

    logic              out_valid_q, out_valid_d;
    word_t             out_data_q, out_data_d;
    logic [NSYM-1:0]   out_datak_q, out_datak_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              locked_q, locked_d;
    logic [3:0]        skp_strip_cnt_q, skp_strip_cnt_d;
    logic [CW-1:0]     com_seen;

    // Stage 1: drop SKPs and compact the survivors toward symbol 0.
    always_comb begin
        logic [CW-1:0] pos;
        // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
        s1_data_d  = '0;
        s1_datak_d = '0;
        s1_skp_d   = '0;
        pos        = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (in_valid) begin
                if (in_datak[i] && (in_data[8*i +: 8] == SKP_SYM)) begin
                    s1_skp_d = s1_skp_d + CW'(1);
                end else begin
                    for (int j = 0; j < NSYM; j++) begin
                        if (pos == CW'(j)) begin
                            s1_data_d[j]  = in_data[8*i +: 8];
                            s1_datak_d[j] = in_datak[i];
                        end
                    end
                    pos = pos + CW'(1);
                end
            end
        end
        s1_cnt_d = pos;
    end

    // Stage 2: append after the current depth, pop one dense word once NSYM symbols are held.
    always_comb begin
        acc_t                cat_data;
        logic [ACC_SYMS-1:0] cat_k;
        logic [DW-1:0]       total;
        cat_data = acc_data_q;
        cat_k    = acc_datak_q;
        for (int k = 0; k < ACC_SYMS; k++) begin
            if (DW'(k) >= depth_q) begin
                cat_data[k] = '0;
                cat_k[k]    = 1'b0;
            end
            for (int j = 0; j < NSYM; j++) begin
                if ((CW'(j) < s1_cnt_q) && (DW'(k) == depth_q + DW'(j))) begin
                    cat_data[k] = s1_data_q[j];
                    cat_k[k]    = s1_datak_q[j];
                end
            end
        end
        total       = depth_q + DW'(s1_cnt_q);
        s2_valid_d  = 1'b0;
        s2_data_d   = '0;
        s2_datak_d  = '0;
        acc_data_d  = cat_data;
        acc_datak_d = cat_k;
        depth_d     = total;
        if (total >= DW'(NSYM)) begin
            s2_valid_d  = 1'b1;
            s2_data_d   = cat_data[NSYM-1:0];
            s2_datak_d  = cat_k[NSYM-1:0];
            acc_data_d  = '0;
            acc_datak_d = '0;
            for (int k = 0; k < ACC_SYMS - NSYM; k++) begin
                acc_data_d[k]  = cat_data[k + NSYM];
                acc_datak_d[k] = cat_k[k + NSYM];
            end
            depth_d = total - DW'(NSYM);
        end
        s2_skp_d = s1_skp_q;
    end

    // Stage 3: per-symbol descramble; a COM reseeds so the very next symbol uses the seed keystream.
    always_comb begin
        logic [15:0] lfsr_run;
        logic        lock_run;
        logic [23:0] step;
        lfsr_run    = lfsr_q;
        lock_run    = locked_q;
        step        = '0;
        com_seen    = '0;
        out_valid_d = s2_valid_q;
        out_data_d  = '0;
        out_datak_d = '0;
        if (s2_valid_q) begin
            for (int i = 0; i < NSYM; i++) begin
                step           = lfsr_byte(lfsr_run);
                out_datak_d[i] = s2_datak_q[i];
                if (s2_datak_q[i] && (s2_data_q[i] == COM_SYM)) begin
                    out_data_d[i] = s2_data_q[i];
                    lfsr_run      = LFSR_SEED;
                    lock_run      = 1'b1;
                    com_seen      = com_seen + CW'(1);
                end else begin
                    out_data_d[i] = (!s2_datak_q[i] && enable && lock_run) ?
                                    (s2_data_q[i] ^ step[7:0]) : s2_data_q[i];
                    lfsr_run      = step[23:8];
                end
            end
        end
        lfsr_d          = lfsr_run;
        locked_d        = lock_run;
        skp_strip_cnt_d = 4'(s2_skp_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    // NOTE: the accumulator storage is cleared on reset too, so no stale symbol can leak after a mid-stream reset.
    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_data_q       <= '0;
            s1_datak_q      <= '0;
            s1_cnt_q        <= '0;
            s1_skp_q        <= '0;
            acc_data_q      <= '0;
            acc_datak_q     <= '0;
            depth_q         <= '0;
            s2_valid_q      <= 1'b0;
            s2_data_q       <= '0;
            s2_datak_q      <= '0;
            s2_skp_q        <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_datak_q     <= '0;
            lfsr_q          <= LFSR_SEED;
            locked_q        <= 1'b0;
            skp_strip_cnt_q <= '0;
        end else begin
            s1_data_q       <= s1_data_d;
            s1_datak_q      <= s1_datak_d;
            s1_cnt_q        <= s1_cnt_d;
            s1_skp_q        <= s1_skp_d;
            acc_data_q      <= acc_data_d;
            acc_datak_q     <= acc_datak_d;
            depth_q         <= depth_d;
            s2_valid_q      <= s2_valid_d;
            s2_data_q       <= s2_data_d;
            s2_datak_q      <= s2_datak_d;
            s2_skp_q        <= s2_skp_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_datak_q     <= out_datak_d;
            lfsr_q          <= lfsr_d;
            locked_q        <= locked_d;
            skp_strip_cnt_q <= skp_strip_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_datak     = out_datak_q;
    assign lfsr_locked   = locked_q;
    assign skp_strip_cnt = skp_strip_cnt_q;

`ifdef USB3_RX_DESCR_STATS_EN
    logic [15:0] skp_total_q, skp_total_d;
    logic [15:0] com_total_q, com_total_d;

    // Totals saturate at all-ones instead of wrapping.
    always_comb begin
        logic [16:0] skp_sum;
        logic [16:0] com_sum;
        skp_sum     = {1'b0, skp_total_q} + 17'(s1_skp_d);
        com_sum     = {1'b0, com_total_q} + 17'(com_seen);
        skp_total_d = skp_sum[16] ? 16'hFFFF : skp_sum[15:0];
        com_total_d = com_sum[16] ? 16'hFFFF : com_sum[15:0];
    end

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            skp_total_q <= '0;
            com_total_q <= '0;
        end else begin
            skp_total_q <= skp_total_d;
            com_total_q <= com_total_d;
        end
    end

    assign skp_total = skp_total_q;
    assign com_total = com_total_q;
`endif

endmodule
